// File: rtl/systolic_layer_ctrl.sv
// Layer sequencer for the systolic MAC array: preload, layer stream, input feed, drain, per layer.
// Optional ready-wait timeout enabled by defining LAYER_CTRL_TIMEOUT_EN.
module systolic_layer_ctrl #(
  parameter int unsigned N_MACS      = 4,
  parameter int unsigned IN_DEPTH    = 256,
  parameter int unsigned DRAIN_CYC   = 8,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [7:0]                cfg_layers,
  input  logic [$clog2(IN_DEPTH):0] cfg_inputs,
  output logic [2:0]                load,
  input  logic                      load_ready,
  input  logic                      layer_ready,
  output logic                      in_load_en,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [7:0]                layer_idx
);

  localparam int unsigned IW      = $clog2(IN_DEPTH) + 1;
  localparam int unsigned StrmCyc = N_MACS / 2;
  localparam int unsigned Lim0    = (StrmCyc > DRAIN_CYC) ? StrmCyc : DRAIN_CYC;
  localparam int unsigned Lim1    = (Lim0 > TIMEOUT_CYC) ? Lim0 : TIMEOUT_CYC;
  localparam int unsigned CW0     = $clog2(Lim1 + 1);
  localparam int unsigned CW      = (CW0 > IW) ? CW0 : IW;

  localparam logic [CW-1:0] StrmLast  = CW'(StrmCyc - 1);
  localparam logic [CW-1:0] DrainLast = CW'(DRAIN_CYC - 1);
`ifdef LAYER_CTRL_TIMEOUT_EN
  localparam logic [CW-1:0] WaitLast  = CW'(TIMEOUT_CYC - 1);
`endif

  typedef enum logic [3:0] {
    StIdle, StWReq, StWWait, StWStrm, StLReq, StLWait, StLStrm, StFeed, StDrain, StFin
  } state_e;

  state_e          state;
  logic [CW-1:0]   cnt;
  logic [7:0]      layers_q;
  logic [IW-1:0]   inputs_q;
  logic [CW-1:0]   feed_last;
  logic            more_layers;

  assign feed_last   = CW'(inputs_q) - CW'(1);
  assign more_layers = ({1'b0, layer_idx} + 9'd1) < {1'b0, layers_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StIdle;
      cnt        <= '0;
      layers_q   <= '0;
      inputs_q   <= '0;
      load       <= 3'b000;
      in_load_en <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      layer_idx  <= '0;
`ifdef LAYER_CTRL_TIMEOUT_EN
      err        <= 1'b0;
`endif
    end else begin
      // Command and pulse outputs are single-cycle unless re-armed below.
      load       <= 3'b000;
      in_load_en <= 1'b0;
      done       <= 1'b0;
      if (abort) begin
        state <= StIdle;
        busy  <= 1'b0;
      end else begin
        unique case (state)
          StIdle: begin
            if (start) begin
              layers_q  <= cfg_layers;
              inputs_q  <= cfg_inputs;
              layer_idx <= '0;
              busy      <= 1'b1;
              cnt       <= '0;
`ifdef LAYER_CTRL_TIMEOUT_EN
              err       <= 1'b0;
`endif
              if (cfg_layers == 8'd0) begin
                state <= StFin;
              end else begin
                state <= StWReq;
                load  <= 3'b001;
              end
            end
          end
          StWReq: begin
            state <= StWWait;
            cnt   <= '0;
          end
          StWWait: begin
            if (load_ready) begin
              state <= StWStrm;
              cnt   <= '0;
`ifdef LAYER_CTRL_TIMEOUT_EN
            end else if (cnt == WaitLast) begin
              state <= StIdle;
              busy  <= 1'b0;
              err   <= 1'b1;
`endif
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          StWStrm: begin
            if (cnt == StrmLast) begin
              state <= StLReq;
              load  <= 3'b010;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          StLReq: begin
            state <= StLWait;
            cnt   <= '0;
          end
          StLWait: begin
            if (layer_ready) begin
              state <= StLStrm;
              cnt   <= '0;
`ifdef LAYER_CTRL_TIMEOUT_EN
            end else if (cnt == WaitLast) begin
              state <= StIdle;
              busy  <= 1'b0;
              err   <= 1'b1;
`endif
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          StLStrm: begin
            if (cnt == StrmLast) begin
              cnt <= '0;
              if (inputs_q == '0) begin
                state <= StDrain;
              end else begin
                state      <= StFeed;
                in_load_en <= 1'b1;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          StFeed: begin
            // in_load_en is registered, so arm the next pulse while pulses remain.
            if (cnt == feed_last) begin
              state <= StDrain;
              cnt   <= '0;
            end else begin
              cnt        <= cnt + CW'(1);
              in_load_en <= 1'b1;
            end
          end
          StDrain: begin
            if (cnt == DrainLast) begin
              cnt <= '0;
              if (more_layers) begin
                layer_idx <= layer_idx + 8'd1;
                state     <= StWReq;
                load      <= 3'b001;
              end else begin
                state <= StFin;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          StFin: begin
            state <= StIdle;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
          default: begin
            state <= StIdle;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifndef LAYER_CTRL_TIMEOUT_EN
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_systolic_layer_ctrl.sv
// Self-checking bench for systolic_layer_ctrl: a per-job timeline model predicts every output cycle.
// Builds with or without LAYER_CTRL_TIMEOUT_EN.
module tb_systolic_layer_ctrl;

  localparam int N_MACS      = 4;
  localparam int IN_DEPTH    = 256;
  localparam int DRAIN_CYC   = 8;
  localparam int TIMEOUT_CYC = 16;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] cfg_layers;
  logic [8:0] cfg_inputs;
  logic [2:0] load;
  logic       load_ready;
  logic       layer_ready;
  logic       in_load_en;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] layer_idx;

  systolic_layer_ctrl #(
    .N_MACS     (N_MACS),
    .IN_DEPTH   (IN_DEPTH),
    .DRAIN_CYC  (DRAIN_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .cfg_layers (cfg_layers),
    .cfg_inputs (cfg_inputs),
    .load       (load),
    .load_ready (load_ready),
    .layer_ready(layer_ready),
    .in_load_en (in_load_en),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .layer_idx  (layer_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One expected output cycle; rw/rl = bench supplies ready, ww/wl = cycle is a wait cycle.
  typedef struct packed {
    logic [2:0] load;
    logic       ine;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] idx;
    logic       rw;
    logic       rl;
    logic       ww;
    logic       wl;
  } exp_t;

  exp_t cur;
  exp_t plan[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc, ine_seen, load_seen, done_seen, busy_seen, done_at;

  function automatic exp_t mk(input logic [2:0] ld, input logic ine, input logic bsy,
                              input logic dn, input logic er, input logic [7:0] idx);
    exp_t e;
    e      = '0;
    e.load = ld;
    e.ine  = ine;
    e.busy = bsy;
    e.done = dn;
    e.err  = er;
    e.idx  = idx;
    return e;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Ready latency in cycles after entering a wait state; negative forces a long wait.
  function automatic int pick(input int maxlat);
    if (maxlat < 0) return 20;
    if (maxlat == 0) return 0;
    if ($urandom_range(0, 5) == 0) return 20;
    return int'($urandom_range(0, 3));
  endfunction

  function automatic bit wait_phase(input bit lyr, input logic [7:0] idx, input int maxlat);
    int   lat;
    exp_t w;
    lat = pick(maxlat);
    w   = mk(3'b000, 1'b0, 1'b1, 1'b0, 1'b0, idx);
    if (lyr) w.wl = 1'b1;
    else w.ww = 1'b1;
`ifdef LAYER_CTRL_TIMEOUT_EN
    if (lat >= TIMEOUT_CYC) begin
      repeat (TIMEOUT_CYC) plan.push_back(w);
      plan.push_back(mk(3'b000, 1'b0, 1'b0, 1'b0, 1'b1, idx));
      return 1'b0;
    end
`endif
    repeat (lat) plan.push_back(w);
    if (lyr) w.rl = 1'b1;
    else w.rw = 1'b1;
    plan.push_back(w);
    return 1'b1;
  endfunction

  function automatic void build(input int nl, input int ni, input int maxlat);
    plan.delete();
    if (nl == 0) begin
      plan.push_back(mk(3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0));
      plan.push_back(mk(3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0));
      return;
    end
    for (int l = 0; l < nl; l++) begin
      plan.push_back(mk(3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 8'(l)));
      if (!wait_phase(1'b0, 8'(l), maxlat)) return;
      repeat (N_MACS / 2) plan.push_back(mk(3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 8'(l)));
      plan.push_back(mk(3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 8'(l)));
      if (!wait_phase(1'b1, 8'(l), maxlat)) return;
      repeat (N_MACS / 2) plan.push_back(mk(3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 8'(l)));
      repeat (ni) plan.push_back(mk(3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 8'(l)));
      repeat (DRAIN_CYC) plan.push_back(mk(3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 8'(l)));
    end
    plan.push_back(mk(3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 8'(nl - 1)));
    plan.push_back(mk(3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 8'(nl - 1)));
  endfunction

  task automatic clr_stats();
    cyc       = 0;
    ine_seen  = 0;
    load_seen = 0;
    done_seen = 0;
    busy_seen = 0;
    done_at   = -1;
  endtask

  // Called at a negedge: compare this cycle, drive inputs, advance the model by one clock.
  task automatic step(input bit st, input int nl, input int ni, input bit ab, input int maxlat);
    exp_t nxt;
    chk("load", {13'd0, load}, {13'd0, cur.load});
    chk("in_load_en", {15'd0, in_load_en}, {15'd0, cur.ine});
    chk("busy", {15'd0, busy}, {15'd0, cur.busy});
    chk("done", {15'd0, done}, {15'd0, cur.done});
    chk("err", {15'd0, err}, {15'd0, cur.err});
    chk("layer_idx", {8'd0, layer_idx}, {8'd0, cur.idx});
    if (in_load_en) ine_seen++;
    if (load != 3'b000) load_seen++;
    if (busy) busy_seen++;
    if (done) begin
      done_seen++;
      done_at = cyc;
    end
    cyc++;
    start       = st;
    abort       = ab;
    cfg_layers  = 8'(nl);
    cfg_inputs  = 9'(ni);
    // Spurious ready pulses outside the matching wait must be ignored.
    load_ready  = cur.rw | (!cur.ww && ($urandom_range(0, 3) == 0));
    layer_ready = cur.rl | (!cur.wl && ($urandom_range(0, 3) == 0));
    if (ab) begin
      plan.delete();
      nxt = mk(3'b000, 1'b0, 1'b0, 1'b0, cur.err, cur.idx);
    end else if (st && !cur.busy) begin
      build(nl, ni, maxlat);
      nxt = plan.pop_front();
    end else if (plan.size() > 0) begin
      nxt = plan.pop_front();
    end else begin
      nxt = mk(3'b000, 1'b0, 1'b0, 1'b0, cur.err, cur.idx);
    end
    @(posedge clk);
    cur = nxt;
    @(negedge clk);
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    cfg_layers  = '0;
    cfg_inputs  = '0;
    load_ready  = 1'b0;
    layer_ready = 1'b0;
    #12;
    chk("rst_load", {13'd0, load}, 16'd0);
    chk("rst_ine", {15'd0, in_load_en}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_done", {15'd0, done}, 16'd0);
    chk("rst_err", {15'd0, err}, 16'd0);
    chk("rst_idx", {8'd0, layer_idx}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cur   = mk(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    plan.delete();

    // One layer, four inputs, immediate ready: 20-cycle layer, FIN, then done.
    clr_stats();
    step(1'b1, 1, 4, 1'b0, 0);
    repeat (29) step(1'b0, 0, 0, 1'b0, 0);
    chk("t1_done_at", 16'(done_at), 16'd22);
    chk("t1_pulses", 16'(ine_seen), 16'd4);
    chk("t1_loads", 16'(load_seen), 16'd2);
    chk("t1_dones", 16'(done_seen), 16'd1);
    chk("t1_idx", {8'd0, layer_idx}, 16'd0);

    // Zero layers: one busy FIN cycle, no loads.
    clr_stats();
    step(1'b1, 0, 3, 1'b0, 0);
    repeat (5) step(1'b0, 0, 0, 1'b0, 0);
    chk("t0_done_at", 16'(done_at), 16'd2);
    chk("t0_busy", 16'(busy_seen), 16'd1);
    chk("t0_loads", 16'(load_seen), 16'd0);

    // Three layers of 18 cycles; a start mid-run is ignored.
    clr_stats();
    step(1'b1, 3, 2, 1'b0, 0);
    for (int i = 1; i <= 62; i++) step(i == 20, 1, 5, 1'b0, 0);
    chk("t3_done_at", 16'(done_at), 16'd56);
    chk("t3_dones", 16'(done_seen), 16'd1);
    chk("t3_pulses", 16'(ine_seen), 16'd6);
    chk("t3_loads", 16'(load_seen), 16'd6);
    chk("t3_idx", {8'd0, layer_idx}, 16'd2);

    // No inputs: drain follows the layer stream directly.
    clr_stats();
    step(1'b1, 1, 0, 1'b0, 0);
    repeat (25) step(1'b0, 0, 0, 1'b0, 0);
    chk("tz_done_at", 16'(done_at), 16'd18);
    chk("tz_pulses", 16'(ine_seen), 16'd0);

    // Abort during the second feed pulse.
    clr_stats();
    step(1'b1, 1, 6, 1'b0, 0);
    repeat (9) step(1'b0, 0, 0, 1'b0, 0);
    step(1'b0, 0, 0, 1'b1, 0);
    repeat (10) step(1'b0, 0, 0, 1'b0, 0);
    chk("ab_pulses", 16'(ine_seen), 16'd2);
    chk("ab_dones", 16'(done_seen), 16'd0);
    chk("ab_busy", {15'd0, busy}, 16'd0);

    // Asynchronous reset mid-stream.
    step(1'b1, 2, 3, 1'b0, 0);
    repeat (12) step(1'b0, 0, 0, 1'b0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_load", {13'd0, load}, 16'd0);
    chk("mr_busy", {15'd0, busy}, 16'd0);
    chk("mr_idx", {8'd0, layer_idx}, 16'd0);
    chk("mr_ine", {15'd0, in_load_en}, 16'd0);
    plan.delete();
    cur = mk(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step(1'b0, 0, 0, 1'b0, 0);

    // Withheld ready: times out when enabled, otherwise just waits.
    clr_stats();
    step(1'b1, 1, 2, 1'b0, -1);
    repeat (69) step(1'b0, 0, 0, 1'b0, 0);
`ifdef LAYER_CTRL_TIMEOUT_EN
    chk("to_err", {15'd0, err}, 16'd1);
    chk("to_dones", 16'(done_seen), 16'd0);
    step(1'b1, 0, 0, 1'b0, 0);
    step(1'b0, 0, 0, 1'b0, 0);
    chk("to_err_clr", {15'd0, err}, 16'd0);
`else
    chk("lw_err", {15'd0, err}, 16'd0);
    chk("lw_done_at", 16'(done_at), 16'd60);
`endif

    // Randomized traffic against the timeline model.
    repeat (3000) begin
      step($urandom_range(0, 7) == 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
           $urandom_range(0, 299) == 0, 3);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
